// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read controller.
//   DATA_WIDTH_DEF : default FIFO word width
//   CNT_WIDTH_DEF  : default delivered-word counter width
//   state_t        : controller FSM states
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer between the FIFO read port and the downstream
// valid/ready interface. Entry 0 is always the head, so head_data and
// head_valid come straight from flops.
//   clk, rst   : clock, async active-high reset
//   push       : write push_data this cycle
//   push_data  : word to write
//   pop        : remove the head (ignored when empty)
//   head_data  : oldest word
//   head_valid : buffer holds at least one word
//   count      : occupancy, 0..2
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic                  vld0_q, vld0_d;
    logic                  vld1_q, vld1_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        vld0_d = vld0_q;
        vld1_d = vld1_q;
        // Pop first, then push into the first free slot; this keeps
        // occupancy unchanged for a simultaneous push and pop.
        if (pop && vld0_q) begin
            ent0_d = ent1_q;
            vld0_d = vld1_q;
            vld1_d = 1'b0;
        end
        if (push) begin
            if (!vld0_d) begin
                ent0_d = push_data;
                vld0_d = 1'b1;
            end else begin
                ent1_d = push_data;
                vld1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            vld0_q <= vld0_d;
            vld1_q <= vld1_d;
        end
    end

    assign head_data  = ent0_q;
    assign head_valid = vld0_q;
    assign count      = {1'b0, vld0_q} + {1'b0, vld1_q};

endmodule

// File: rtl/fifo_read_ctrl.sv
// Reads words from a synchronous FIFO (data one cycle after rd_en) and
// presents them on a valid/ready stream through a 2-entry skid buffer.
//   clk, rst      : clock, async active-high reset
//   enable        : permits new FIFO reads
//   empty         : FIFO empty flag
//   almostempty   : FIFO holds one word (not used for control)
//   underflow     : FIFO underflow, valid in the in-flight cycle
//   data_out      : FIFO read data, valid in the in-flight cycle
//   rd_en         : FIFO read request
//   m_data/m_valid/m_ready : downstream stream
//   busy          : read in flight or buffer non-empty
//   word_cnt      : handshakes completed, wraps
//   err_underflow : sticky underflow error
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | no reads issued, waiting for enable
// RUN      | issuing reads while buffer space allows
// STOPPING | enable dropped; draining in-flight read, no new reads
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  empty,
    input  logic                  almostempty,
    input  logic                  underflow,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  err_underflow
);

    state_t                 state_q, state_d;
    logic                   inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]   word_cnt_q, word_cnt_d;
    logic                   err_q, err_d;

    logic [DATA_WIDTH-1:0]  buf_head;
    logic                   buf_valid;
    logic [1:0]             buf_count;
    logic                   capture;
    logic                   handshake;
    logic [2:0]             pending;
    logic                   unused_almostempty;

    assign unused_almostempty = almostempty;

    assign handshake = buf_valid & m_ready;
    // An underflowed read is dropped rather than buffered.
    assign capture   = inflight_q & ~underflow;
    // Occupancy after this cycle's pop plus the in-flight word; counting
    // the pop is what lets reads continue back-to-back with m_ready high.
    assign pending   = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, handshake};

    always_comb begin
        state_d    = state_q;
        rd_en      = 1'b0;
        inflight_d = 1'b0;
        word_cnt_d = word_cnt_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                rd_en = ~empty & (pending < 3'd2);
                if (!enable) state_d = STOPPING;
            end
            STOPPING: begin
                if (enable) begin
                    state_d = RUN;
                end else if (!inflight_q && buf_count == 2'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The in-flight flag is rd_en delayed by one cycle.
        inflight_d = rd_en;
        if (handshake) word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
        if (inflight_q && underflow) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (capture),
        .push_data  (data_out),
        .pop        (handshake),
        .head_data  (buf_head),
        .head_valid (buf_valid),
        .count      (buf_count)
    );

    assign m_data        = buf_head;
    assign m_valid       = buf_valid;
    assign busy          = inflight_q | (buf_count != 2'd0);
    assign word_cnt      = word_cnt_q;
    assign err_underflow = err_q;

endmodule
